// File: rtl/mimic_circuit_adder_128.sv
// XNOR-popcount datapath for binarized-NN dot products: sum = popcount(inx ~^ iny).
// Define MIMIC_PIPE_EN to register the group counts, which raises the latency from 1 to 2 cycles.
module mimic_circuit_adder_128 #(
    parameter int WIDTH = 128,
    parameter int GROUP = 20,
    parameter int SUM_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] inx,
    input  logic [WIDTH-1:0] iny,
    output logic             out_valid,
    output logic [SUM_W-1:0] sum
);

    localparam int NUM_GRP = 6;
    localparam int LAST_W  = WIDTH - NUM_GRP * GROUP;

    // Each group is built from small counters so that it maps onto short adder chains.
    function automatic logic [2:0] count5(input logic [4:0] v);
        return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]} + {2'b00, v[4]};
    endfunction

    function automatic logic [2:0] count4(input logic [3:0] v);
        return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

    function automatic logic [4:0] count20(input logic [19:0] v);
        logic [2:0] c0;
        logic [2:0] c1;
        logic [2:0] c2;
        logic [2:0] c3;
        c0 = count5(v[4:0]);
        c1 = count5(v[9:5]);
        c2 = count5(v[14:10]);
        c3 = count5(v[19:15]);
        return {2'b00, c0} + {2'b00, c1} + {2'b00, c2} + {2'b00, c3};
    endfunction

    function automatic logic [3:0] count8(input logic [7:0] v);
        logic [2:0] lo;
        logic [2:0] hi;
        lo = count4(v[3:0]);
        hi = count4(v[7:4]);
        return {1'b0, lo} + {1'b0, hi};
    endfunction

    logic [WIDTH-1:0] xnor_v;
    logic [4:0]       grp_cnt [NUM_GRP];
    logic [3:0]       last_cnt;

    assign xnor_v = inx ~^ iny;

    always_comb begin
        for (int g = 0; g < NUM_GRP; g++) begin
            grp_cnt[g] = count20(xnor_v[g*GROUP +: GROUP]);
        end
        last_cnt = count8(xnor_v[WIDTH-1 -: LAST_W]);
    end

    logic [4:0] tree_grp [NUM_GRP];
    logic [3:0] tree_last;
    logic       tree_valid;

`ifdef MIMIC_PIPE_EN
    // The group counts are loaded on every cycle; tree_valid tells the output stage whether they are meaningful.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int g = 0; g < NUM_GRP; g++) begin
                tree_grp[g] <= '0;
            end
            tree_last  <= '0;
            tree_valid <= 1'b0;
        end else begin
            for (int g = 0; g < NUM_GRP; g++) begin
                tree_grp[g] <= grp_cnt[g];
            end
            tree_last  <= last_cnt;
            tree_valid <= in_valid;
        end
    end
`else
    always_comb begin
        for (int g = 0; g < NUM_GRP; g++) begin
            tree_grp[g] = grp_cnt[g];
        end
        tree_last  = last_cnt;
        tree_valid = in_valid;
    end
`endif

    logic [5:0] pair01;
    logic [5:0] pair23;
    logic [5:0] pair45;
    logic [6:0] quad0123;
    logic [6:0] tail;
    logic [7:0] total;

    // Each level widens by one bit, so the worst case (all 128 bits agree) never wraps.
    always_comb begin
        pair01   = {1'b0, tree_grp[0]} + {1'b0, tree_grp[1]};
        pair23   = {1'b0, tree_grp[2]} + {1'b0, tree_grp[3]};
        pair45   = {1'b0, tree_grp[4]} + {1'b0, tree_grp[5]};
        quad0123 = {1'b0, pair01} + {1'b0, pair23};
        tail     = {1'b0, pair45} + {3'b000, tree_last};
        total    = {1'b0, quad0123} + {1'b0, tail};
    end

    // The result register holds its value through bubbles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= tree_valid;
            if (tree_valid) begin
                sum <= total;
            end
        end
    end

endmodule

// File: tb/tb_mimic_circuit_adder_128.sv
// Directed plus random bench for mimic_circuit_adder_128, with an in-order scoreboard.
// Define MIMIC_PIPE_EN to match a pipelined build; the bench then expects a latency of 2 cycles.
module tb_mimic_circuit_adder_128;

`ifdef MIMIC_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic [127:0] inx = '0;
    logic [127:0] iny = '0;
    logic         out_valid;
    logic [7:0]   sum;

    logic [7:0]   exp_in = '0;
    int           cyc = 0;
    int           checks = 0;
    int           errors = 0;
    logic [7:0]   last_exp = '0;

    typedef struct {
        logic [7:0] val;
        int         due;
    } exp_t;
    exp_t exp_q[$];

    logic [127:0] dir_x [9];
    logic [127:0] dir_y [9];
    logic [7:0]   dir_s [9];

    mimic_circuit_adder_128 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .inx       (inx),
        .iny       (iny),
        .out_valid (out_valid),
        .sum       (sum)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] golden(input logic [127:0] x, input logic [127:0] y);
        int n = 0;
        for (int i = 0; i < 128; i++) begin
            if (x[i] == y[i]) n++;
        end
        return 8'(n);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, want, $time);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [127:0] x, input logic [127:0] y,
                                 input logic [7:0] e);
        @(negedge clk);
        in_valid = v;
        inx      = x;
        iny      = y;
        exp_in   = e;
    endtask

    // Record the expected result with the cycle on which it must appear.
    always @(posedge clk) begin
        cyc++;
        if (!rst && in_valid) exp_q.push_back('{val: exp_in, due: cyc + LAT - 1});
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                checkOutput("out_valid", 32'(out_valid), 32'd1);
                checkOutput("sum", 32'(sum), 32'(exp_q[0].val));
                last_exp = exp_q[0].val;
                void'(exp_q.pop_front());
            end else begin
                checkOutput("bubble_valid", 32'(out_valid), 32'd0);
                checkOutput("hold_sum", 32'(sum), 32'(last_exp));
            end
        end
    end

    initial begin
        dir_x[0] = '0;                   dir_y[0] = '1;                   dir_s[0] = 8'd0;
        dir_x[1] = '0;                   dir_y[1] = '0;                   dir_s[1] = 8'd128;
        dir_x[2] = '0;                   dir_y[2] = {32{4'h1}};           dir_s[2] = 8'd96;
        dir_x[3] = '0;                   dir_y[3] = {32{4'h3}};           dir_s[3] = 8'd64;
        dir_x[4] = '0;                   dir_y[4] = {4{32'h12345678}};    dir_s[4] = 8'd76;
        dir_x[5] = '0;                   dir_y[5] = 128'hFFFFFFFFFFFFFFFFFFFFF0FFFFFFFFF0;
                                                                          dir_s[5] = 8'd8;
        dir_x[6] = '0;                   dir_y[6] = {{31{4'hF}}, 4'h7};   dir_s[6] = 8'd1;
        dir_x[7] = '0;                   dir_y[7] = 128'h00000000000010000000000000000000;
                                                                          dir_s[7] = 8'd127;
        dir_x[8] = {16{8'hC3}};          dir_y[8] = {16{8'hC3}};          dir_s[8] = 8'd128;

        #2 rst = 1'b1;
        #2;
        checkOutput("reset_sum", 32'(sum), 32'd0);
        checkOutput("reset_valid", 32'(out_valid), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        $display("[TB] isolated directed vectors");
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b1, dir_x[i], dir_y[i], dir_s[i]);
            repeat (LAT + 1) applyStimulus(1'b0, '0, '0, '0);
        end

        $display("[TB] back-to-back directed vectors");
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b1, dir_x[i], dir_y[i], dir_s[i]);
        end
        repeat (LAT + 2) applyStimulus(1'b0, '0, '0, '0);

        $display("[TB] reset mid-stream");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, dir_x[i + 2], dir_y[i + 2], dir_s[i + 2]);
        end
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("midreset_sum", 32'(sum), 32'd0);
        checkOutput("midreset_valid", 32'(out_valid), 32'd0);
        exp_q.delete();
        last_exp = '0;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("inreset_valid", 32'(out_valid), 32'd0);
        rst = 1'b0;
        applyStimulus(1'b1, dir_x[4], dir_y[4], dir_s[4]);
        repeat (LAT + 2) applyStimulus(1'b0, '0, '0, '0);

        $display("[TB] random vectors");
        for (int n = 0; n < 10000; ) begin
            logic [127:0] x;
            logic [127:0] y;
            int mode;
            x = {$urandom, $urandom, $urandom, $urandom};
            mode = int'($urandom_range(0, 3));
            case (mode)
                0:       y = {$urandom, $urandom, $urandom, $urandom};
                1:       y = x;
                2:       y = ~x;
                default: y = x ^ (128'd1 << $urandom_range(0, 127));
            endcase
            if ($urandom_range(0, 3) != 0) begin
                applyStimulus(1'b1, x, y, golden(x, y));
                n++;
            end else begin
                applyStimulus(1'b0, x, y, '0);
            end
        end
        repeat (LAT + 3) applyStimulus(1'b0, '0, '0, '0);
        checkOutput("drain", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
